spi_hub: RTL and testbench

Parametrised SPI slave that bridges the MCU to the FPGA's configuration registers, the ADC capture buffer and the DDS wave tables. It generalises the fixed one-ADC/two-DDS front end to NUM_CFG config registers of CFG_W bits and NUM_TBL byte-wide write tables. It adds:
- atomic commit on chip-select release, with abort detection and an error counter;
- a 16-bit start-address header on table writes;
- per-register update strobes.

---
 rtl/spi_hub_pkg.sv | 33 +++
 rtl/spi_hub_if.sv | 12 +
 rtl/spi_hub_edge_sync.sv | 44 ++++
 rtl/spi_hub.sv | 205 ++++++++++++++++++++
 tb/tb_spi_hub.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_hub_pkg.sv
// Shared definitions for the SPI configuration hub: command byte fields,
// special address codes, FSM state encoding and the command decoder.
package spi_hub_pkg;

   localparam int W_BIT = 7;
   localparam int A_MSB = 3;

   localparam logic [3:0] ADDR_TBL_BASE = 4'h8;
   localparam logic [3:0] ADDR_BUF      = 4'hE;
   localparam logic [3:0] ADDR_ID       = 4'hF;

   typedef enum logic [3:0] {
      IDLE, CMD, CFG, STAT, BUF, TADDR, TDATA, ID, DRAIN
   } state_t;

   // Map the command address nibble onto the state that serves it.
   function automatic state_t decode_cmd(input logic [3:0] a, input int num_cfg,
                                         input int num_tbl);
      state_t s;
      if (int'(a) < num_cfg)
         s = CFG;
      else if (a == ADDR_BUF)
         s = STAT;
      else if (a == ADDR_ID)
         s = ID;
      else if (a >= ADDR_TBL_BASE && int'(a) < int'(ADDR_TBL_BASE) + num_tbl)
         s = TADDR;
      else
         s = DRAIN;
      return s;
   endfunction

endpackage

// File: rtl/spi_hub_if.sv
// SPI pin bundle between the MCU (master) and the hub (slave).
//   ncs_spi, sck_spi, mosi_spi : master -> slave, asynchronous to clk
//   miso_spi                   : slave -> master
interface spi_hub_if;
   logic ncs_spi;
   logic sck_spi;
   logic mosi_spi;
   logic miso_spi;

   modport slave  (input ncs_spi, sck_spi, mosi_spi, output miso_spi);
   modport master (output ncs_spi, sck_spi, mosi_spi, input miso_spi);
endinterface

// File: rtl/spi_hub_edge_sync.sv
// Two-flop synchronisers for the raw SPI pins plus an edge-detect stage.
//   clk, rst_n        : system clock, async active-low reset
//   ncs, sck, mosi    : raw pins
//   sck_rise/sck_fall : one-clk pulses on synchronised sck edges
//   ncs_rise/ncs_fall : one-clk pulses on synchronised ncs edges
//   mosi_s            : mosi aligned with the sck edge pulses
module spi_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic ncs,
   input  logic sck,
   input  logic mosi,
   output logic sck_rise,
   output logic sck_fall,
   output logic ncs_rise,
   output logic ncs_fall,
   output logic mosi_s
);

   logic [2:0] ncs_r;
   logic [2:0] sck_r;
   logic [1:0] mosi_r;

   // ncs history resets low: if reset releases while ncs is still low, no
   // fall is seen, so the interrupted transaction is ignored until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ncs_r  <= '0;
         sck_r  <= '0;
         mosi_r <= '0;
      end else begin
         ncs_r  <= {ncs_r[1:0], ncs};
         sck_r  <= {sck_r[1:0], sck};
         mosi_r <= {mosi_r[0], mosi};
      end
   end

   assign sck_rise = sck_r[1] & ~sck_r[2];
   assign sck_fall = ~sck_r[1] & sck_r[2];
   assign ncs_rise = ncs_r[1] & ~ncs_r[2];
   assign ncs_fall = ~ncs_r[1] & ncs_r[2];
   assign mosi_s   = mosi_r[1];

endmodule

// File: rtl/spi_hub.sv
// SPI slave bridging the MCU to config registers, capture buffer and tables.
//   clk, rst_n : system clock, async active-low reset
//   spi        : SPI pins (slave modport)
//   cfg_q/cfg_upd        : config registers and per-register commit strobes
//   status_in            : status word shifted out ahead of buffer data
//   buf_addr/buf_data    : capture buffer read port (1-clk latency)
//   tbl_addr/tbl_data/tbl_we : shared table write port, one-hot strobe
//   err_cnt              : saturating count of errored transactions
//
// state | meaning
// IDLE  | waiting for ncs fall
// CMD   | receiving command byte, shifting out DEVICE_ID
// CFG   | config read/write, commit on ncs rise
// STAT  | shifting out latched status word
// BUF   | streaming capture buffer words
// TADDR | receiving 16-bit table start address
// TDATA | receiving table data bytes
// ID    | repeating DEVICE_ID
// DRAIN | unknown address, ignore until ncs rise
module spi_hub
   import spi_hub_pkg::*;
#(
   parameter int          NUM_CFG   = 4,
   parameter int          CFG_W     = 32,
   parameter int          NUM_TBL   = 2,
   parameter int          TBL_AW    = 9,
   parameter int          BUF_AW    = 12,
   parameter logic [7:0]  DEVICE_ID = 8'h91
) (
   input  logic                     clk,
   input  logic                     rst_n,
   spi_hub_if.slave                 spi,
   output logic [NUM_CFG*CFG_W-1:0] cfg_q,
   output logic [NUM_CFG-1:0]       cfg_upd,
   input  logic [15:0]              status_in,
   output logic [BUF_AW-1:0]        buf_addr,
   input  logic [15:0]              buf_data,
   output logic [TBL_AW-1:0]        tbl_addr,
   output logic [7:0]               tbl_data,
   output logic [NUM_TBL-1:0]       tbl_we,
   output logic [7:0]               err_cnt
);

   localparam int SH_W  = (CFG_W > 16) ? CFG_W : 16;
   localparam int CNT_W = $clog2(SH_W + 1);

   logic sck_rise, sck_fall, ncs_rise, ncs_fall, mosi_s;
   state_t state, state_nxt, dec_state;
   logic [SH_W-1:0]  shifter;
   logic [CNT_W-1:0] bit_cnt;
   logic             cmd_w;
   logic [2:0]       cfg_idx;
   logic [1:0]       tbl_sel;
   logic             load_pend;
   logic             miso_q;
   logic [7:0]       cmd_byte;
   logic [CFG_W-1:0] cfg_rd;
   logic             byte_done, word_done, cfg_full;
   logic             commit, err_inc, out_en;

   spi_edge_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .ncs      (spi.ncs_spi),
      .sck      (spi.sck_spi),
      .mosi     (spi.mosi_spi),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .ncs_rise (ncs_rise),
      .ncs_fall (ncs_fall),
      .mosi_s   (mosi_s)
   );

   assign spi.miso_spi = miso_q;

   // The byte completing on this rising edge, including the bit being sampled.
   assign cmd_byte  = {shifter[6:0], mosi_s};
   assign dec_state = decode_cmd(cmd_byte[A_MSB:0], NUM_CFG, NUM_TBL);
   assign byte_done = (bit_cnt == CNT_W'(7));
   assign word_done = (bit_cnt == CNT_W'(15));
   assign cfg_full  = (bit_cnt == CNT_W'(CFG_W));
   assign commit    = ncs_rise && state == CFG && cmd_w && cfg_full;
   assign err_inc   = (state == CMD && sck_rise && byte_done && dec_state == DRAIN) ||
                      (ncs_rise && state == CFG && cmd_w && bit_cnt != '0 && !cfg_full);
   assign out_en    = (state == CMD) || (state == CFG) || (state == STAT) ||
                      (state == BUF) || (state == ID);

   always_comb begin
      cfg_rd = '0;
      for (int k = 0; k < NUM_CFG; k++)
         if (cmd_byte[A_MSB:0] == 4'(k))
            cfg_rd = cfg_q[k*CFG_W +: CFG_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ncs_fall) state_nxt = CMD;
         CMD:     if (sck_rise && byte_done) state_nxt = dec_state;
         STAT:    if (sck_rise && word_done) state_nxt = BUF;
         TADDR:   if (sck_rise && word_done) state_nxt = TDATA;
         default: ;
      endcase
      if (ncs_rise) state_nxt = IDLE;
   end

   // mosi shifts in on rising edges; miso is re-registered from the shifter
   // MSB on falling edges, so a load on a rising edge appears at the next fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q     <= '0;
         cfg_upd   <= '0;
         buf_addr  <= '0;
         tbl_addr  <= '0;
         tbl_data  <= '0;
         tbl_we    <= '0;
         err_cnt   <= '0;
         shifter   <= '0;
         bit_cnt   <= '0;
         cmd_w     <= 1'b0;
         cfg_idx   <= '0;
         tbl_sel   <= '0;
         load_pend <= 1'b0;
         miso_q    <= 1'b0;
      end else begin
         cfg_upd <= '0;
         tbl_we  <= '0;
         if (|tbl_we) tbl_addr <= tbl_addr + 1'b1;
         if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

         if (ncs_rise) begin
            miso_q    <= 1'b0;
            load_pend <= 1'b0;
            if (commit)
               for (int k = 0; k < NUM_CFG; k++)
                  if (cfg_idx == 3'(k)) begin
                     cfg_q[k*CFG_W +: CFG_W] <= shifter[CFG_W-1:0];
                     cfg_upd[k]              <= 1'b1;
                  end
         end else if (state == IDLE) begin
            if (ncs_fall) begin
               shifter   <= SH_W'(DEVICE_ID) << (SH_W - 8);
               miso_q    <= DEVICE_ID[7];
               bit_cnt   <= '0;
               load_pend <= 1'b0;
            end
         end else if (sck_rise) begin
            shifter <= {shifter[SH_W-2:0], mosi_s};
            bit_cnt <= bit_cnt + 1'b1;
            case (state)
               CMD: if (byte_done) begin
                  bit_cnt <= '0;
                  cmd_w   <= cmd_byte[W_BIT];
                  cfg_idx <= cmd_byte[2:0];
                  tbl_sel <= cmd_byte[1:0];
                  case (dec_state)
                     CFG:  shifter <= SH_W'(cfg_rd) << (SH_W - CFG_W);
                     STAT: begin
                        shifter  <= SH_W'(status_in) << (SH_W - 16);
                        buf_addr <= '0;
                     end
                     ID:   shifter <= SH_W'(DEVICE_ID) << (SH_W - 8);
                     default: ;
                  endcase
               end
               // Saturate so any overlong write still commits the last CFG_W bits.
               CFG: if (cfg_full) bit_cnt <= bit_cnt;
               STAT, BUF: if (word_done) begin
                  bit_cnt   <= '0;
                  load_pend <= 1'b1;
               end
               TADDR: if (word_done) begin
                  bit_cnt  <= '0;
                  tbl_addr <= TBL_AW'({shifter[14:0], mosi_s});
               end
               TDATA: if (byte_done) begin
                  bit_cnt  <= '0;
                  tbl_data <= cmd_byte;
                  tbl_we   <= NUM_TBL'(1) << tbl_sel;
               end
               ID: if (byte_done) begin
                  bit_cnt <= '0;
                  shifter <= SH_W'(DEVICE_ID) << (SH_W - 8);
               end
               default: ;
            endcase
         end else if (sck_fall) begin
            if (load_pend) begin
               shifter   <= SH_W'(buf_data) << (SH_W - 16);
               miso_q    <= buf_data[15];
               buf_addr  <= buf_addr + 1'b1;
               load_pend <= 1'b0;
            end else begin
               miso_q <= out_en & shifter[SH_W-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_hub.sv
module tb_spi_hub;

   localparam int HALF = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic [15:0]  status_in;
   logic [127:0] cfg_q, cfg_q2;
   logic [3:0]   cfg_upd, cfg_upd2;
   logic [11:0]  buf_addr;
   logic [1:0]   buf_addr2;
   logic [15:0]  buf_data, buf_data2;
   logic [8:0]   tbl_addr, tbl_addr2;
   logic [7:0]   tbl_data, tbl_data2;
   logic [1:0]   tbl_we, tbl_we2;
   logic [7:0]   err_cnt, err_cnt2;

   spi_hub_if spi ();
   spi_hub_if spi2 ();
   assign spi2.ncs_spi  = spi.ncs_spi;
   assign spi2.sck_spi  = spi.sck_spi;
   assign spi2.mosi_spi = spi.mosi_spi;

   spi_hub dut (
      .clk(clk), .rst_n(rst_n), .spi(spi), .cfg_q(cfg_q), .cfg_upd(cfg_upd),
      .status_in(status_in), .buf_addr(buf_addr), .buf_data(buf_data),
      .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_we(tbl_we), .err_cnt(err_cnt)
   );

   // Small-buffer instance sharing the pins, used to reach the address wrap.
   spi_hub #(.BUF_AW(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .spi(spi2), .cfg_q(cfg_q2), .cfg_upd(cfg_upd2),
      .status_in(status_in), .buf_addr(buf_addr2), .buf_data(buf_data2),
      .tbl_addr(tbl_addr2), .tbl_data(tbl_data2), .tbl_we(tbl_we2), .err_cnt(err_cnt2)
   );

   always @(posedge clk) begin
      buf_data  <= 16'h0100 + {4'h0, buf_addr};
      buf_data2 <= 16'h0100 + {14'h0, buf_addr2};
   end

   int upd_cnt [4];
   int we0_cnt = 0;
   int we1_cnt = 0;
   logic [8:0] we_addr [$];
   logic [7:0] we_data [$];

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) if (cfg_upd[k]) upd_cnt[k]++;
      if (tbl_we[0]) we0_cnt++;
      if (tbl_we[1]) begin
         we1_cnt++;
         we_addr.push_back(tbl_addr);
         we_data.push_back(tbl_data);
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic cs_low();
      spi.ncs_spi = 1'b0;
      repeat (HALF + 1) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (HALF) @(negedge clk);
      spi.ncs_spi = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic shift_bits(input int n, input logic [127:0] tx,
                             output logic [127:0] rx, output logic [127:0] rx2);
      rx  = '0;
      rx2 = '0;
      for (int i = n - 1; i >= 0; i--) begin
         spi.mosi_spi = tx[i];
         repeat (HALF) @(negedge clk);
         spi.sck_spi = 1'b1;
         rx[i]  = spi.miso_spi;
         rx2[i] = spi2.miso_spi;
         repeat (HALF) @(negedge clk);
         spi.sck_spi = 1'b0;
      end
   endtask

   task automatic xfer(input int n, input logic [127:0] tx,
                       output logic [127:0] rx, output logic [127:0] rx2);
      cs_low();
      shift_bits(n, tx, rx, rx2);
      cs_high();
   endtask

   logic [127:0] rx, rx2;
   int u0, u1, u2, u3, w0, w1, base;

   initial begin
      spi.ncs_spi  = 1'b1;
      spi.sck_spi  = 1'b0;
      spi.mosi_spi = 1'b0;
      status_in    = 16'h1234;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      chk_eq("rst_cfg_q", cfg_q, 128'h0);
      chk_eq("rst_misc", {err_cnt, tbl_addr, tbl_data, tbl_we, buf_addr, cfg_upd},
             '0);
      chk_eq("rst_miso", spi.miso_spi, 1'b0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // config read, write, read back
      u2 = upd_cnt[2];
      xfer(40, {8'h02, 32'hDEADBEEF}, rx, rx2);
      chk_eq("rd2_miso", rx[39:0], {8'h91, 32'h0});
      chk_eq("rd2_no_upd", upd_cnt[2] - u2, 0);
      chk_eq("rd2_cfg_q", cfg_q, 128'h0);
      xfer(40, {8'h82, 32'hDEADBEEF}, rx, rx2);
      chk_eq("wr2_miso", rx[39:0], {8'h91, 32'h0});
      chk_eq("wr2_upd", upd_cnt[2] - u2, 1);
      chk_eq("wr2_cfg_q", cfg_q, {32'h0, 32'hDEADBEEF, 64'h0});
      xfer(40, {8'h02, 32'h0}, rx, rx2);
      chk_eq("rdback2", rx[39:0], {8'h91, 32'hDEADBEEF});

      // abort, overlong write, empty write
      u0 = upd_cnt[0]; u1 = upd_cnt[1]; u2 = upd_cnt[2]; u3 = upd_cnt[3];
      xfer(28, {8'h81, 20'hABCDE}, rx, rx2);
      chk_eq("abort_cfg_q", cfg_q, {32'h0, 32'hDEADBEEF, 64'h0});
      chk_eq("abort_upd", (upd_cnt[0]-u0)+(upd_cnt[1]-u1)+(upd_cnt[2]-u2)+(upd_cnt[3]-u3), 0);
      chk_eq("abort_err", err_cnt, 8'd1);
      xfer(48, {8'h83, 40'h11CAFEF00D}, rx, rx2);
      chk_eq("long_cfg_q", cfg_q, {32'hCAFEF00D, 32'hDEADBEEF, 64'h0});
      chk_eq("long_upd", upd_cnt[3] - u3, 1);
      xfer(8, {8'h80}, rx, rx2);
      chk_eq("empty_upd", upd_cnt[0] - u0, 0);
      chk_eq("empty_err", err_cnt, 8'd1);

      // ID read
      xfer(24, {8'h0F, 16'h0}, rx, rx2);
      chk_eq("id_miso", rx[23:0], 24'h919191);

      // buffer stream
      xfer(72, {8'h0E, 64'h0}, rx, rx2);
      chk_eq("buf_miso", rx[71:0], {8'h91, 64'h1234_0100_0101_0102});
      chk_eq("buf_addr_end", buf_addr, 12'd4);
      xfer(104, {8'h0E, 96'h0}, rx, rx2);
      chk_eq("wrap_status", rx2[95:80], 16'h1234);
      chk_eq("wrap_words", rx2[31:0], {16'h0103, 16'h0100});
      chk_eq("wrap_addr_end", buf_addr2, 2'd2);

      // table write with trailing partial byte
      base = we_addr.size(); w0 = we0_cnt; w1 = we1_cnt;
      xfer(52, {8'h89, 16'h01FE, 8'hAA, 8'hBB, 8'hCC, 4'hF}, rx, rx2);
      chk_eq("tbl_miso", rx[51:0], {8'h91, 44'h0});
      chk_eq("tbl_we1_cnt", we1_cnt - w1, 3);
      chk_eq("tbl_we0_cnt", we0_cnt - w0, 0);
      if (we_addr.size() >= base + 3) begin
         chk_eq("tbl_wr0", {we_addr[base], we_data[base]}, {9'h1FE, 8'hAA});
         chk_eq("tbl_wr1", {we_addr[base+1], we_data[base+1]}, {9'h1FF, 8'hBB});
         chk_eq("tbl_wr2", {we_addr[base+2], we_data[base+2]}, {9'h000, 8'hCC});
      end else begin
         chk_eq("tbl_log_size", we_addr.size() - base, 3);
      end
      chk_eq("tbl_addr_end", tbl_addr, 9'h001);
      chk_eq("tbl_err", err_cnt, 8'd1);

      // bad address and saturation
      xfer(16, {8'h0B, 8'hFF}, rx, rx2);
      chk_eq("bad_miso", rx[15:0], 16'h9100);
      chk_eq("bad_err", err_cnt, 8'd2);
      for (int i = 0; i < 253; i++) xfer(8, {8'h0B}, rx, rx2);
      chk_eq("err_reach255", err_cnt, 8'd255);
      for (int i = 0; i < 3; i++) xfer(8, {8'h0B}, rx, rx2);
      chk_eq("err_sat", err_cnt, 8'd255);

      // reset in the middle of a write
      u0 = upd_cnt[0]; u1 = upd_cnt[1];
      cs_low();
      shift_bits(20, {8'h80, 12'hABC}, rx, rx2);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_eq("midrst_cfg_q", cfg_q, 128'h0);
      chk_eq("midrst_misc", {err_cnt, tbl_addr, tbl_data, tbl_we, buf_addr, cfg_upd}, '0);
      chk_eq("midrst_miso", spi.miso_spi, 1'b0);
      rst_n = 1'b1;
      shift_bits(20, {20'h12345}, rx, rx2);
      cs_high();
      chk_eq("postrst_upd", upd_cnt[0] - u0, 0);
      chk_eq("postrst_cfg_q", cfg_q, 128'h0);
      chk_eq("postrst_err", err_cnt, 8'd0);
      xfer(40, {8'h81, 32'h12345678}, rx, rx2);
      chk_eq("after_miso", rx[39:0], {8'h91, 32'h0});
      chk_eq("after_upd", upd_cnt[1] - u1, 1);
      chk_eq("after_cfg_q", cfg_q, {64'h0, 32'h12345678, 32'h0});
      chk_eq("after_cfg_q2", cfg_q2, {64'h0, 32'h12345678, 32'h0});
      chk_eq("after_err2", err_cnt2, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
